// File: rtl/uart_tx_fifo_rd_pkg.sv
// Shared FSM state encoding and frame constants for the FIFO-draining UART transmitter.
package uart_tx_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LATCH,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_rd_if.sv
// FIFO read port plus serial-line status of uart_tx_fifo_rd.
// master = the transmitter, slave = the FIFO / line observer.
interface uart_tx_fifo_rd_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;
    logic              tx;
    logic              busy;
    logic              tx_done;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter: bit_end pulses on the last cycle of each CLKS_PER_BIT-long bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);
    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = en && (cnt_q == LAST);

    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_fifo_rd.sv
// UART transmitter that pops bytes from a registered-output FIFO and sends 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo_rd
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_fifo_rd_if.master      bus
);
    localparam int               BIT_W    = $clog2(UART_DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif
    logic              bit_end;
    logic              baud_clr;
    logic              baud_en;

    // Every state change restarts the bit timer, so each state gets full bit periods.
    assign baud_clr = (state_d != state_q);
    assign baud_en  = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clr     (baud_clr),
        .en      (baud_en),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE:    if (!bus.fifo_empty) state_d = RD;
            RD:      state_d = LATCH;
            LATCH: begin
                // FIFO data_out is registered: it is valid here, one cycle after the pop.
                shift_d = bus.fifo_data;
`ifdef UART_TX_PARITY_EN
                parity_d = ^bus.fifo_data;
`endif
                state_d = START;
            end
            START:   if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY:  if (bit_end) state_d = STOP;
`endif
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so tx is registered yet aligned.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.tx      = tx_q;
    assign bus.fifo_rd = (state_q == RD);
    assign bus.busy    = (state_q != IDLE);
    assign bus.tx_done = (state_q == STOP) && bit_end;
endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// Scoreboard bench for uart_tx_fifo_rd: FIFO model feeds bytes, a line monitor decodes frames.
module tb_uart_tx_fifo_rd;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] F_00 = 11'b1_0_00000000_0;
    localparam logic [10:0] F_FF = 11'b1_0_11111111_0;
    localparam logic [10:0] F_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] F_07 = 11'b1_1_00000111_0;
`else
    localparam int FRAME_BITS = 10;
    localparam logic [10:0] F_A5 = 11'b0_1_10100101_0;
    localparam logic [10:0] F_00 = 11'b0_1_00000000_0;
    localparam logic [10:0] F_FF = 11'b0_1_11111111_0;
    localparam logic [10:0] F_3C = 11'b0_1_00111100_0;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
        bit          b2b;
        bit          abort;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_rd_if #(.DATA_W(8)) bus ();

    uart_tx_fifo_rd #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rd_count = 0;
    int   ncyc     = 0;
    int   last_rd  = -1000;
    bit   mon_active = 1'b0;
    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic [10:0] f, input bit b2b, input bit abort);
        exp_t e;
        e.data = d; e.frame = f; e.b2b = b2b; e.abort = abort;
        fifo_q.push_back(d);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (exp_q.size() == 0 && !mon_active), 1);
    endtask

    // FIFO model: registered data_out updates on the edge that ends the rd cycle.
    initial begin : fifo_model
        bus.fifo_data  = 8'h00;
        bus.fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.fifo_rd) begin
                rd_count++;
                @(posedge clk);
                #1;
                if (fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
                @(negedge clk);
                check("rd_single_pulse", bus.fifo_rd, 0);
            end
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (bus.fifo_rd) last_rd = ncyc;
    endtask

    initial begin : monitor
        logic                 prev_tx = 1'b1;
        int                   start_cyc;
        int                   last_end = -1000;
        bit                   aborted;
        exp_t                 e;
        logic [7:0]           got;
        int                   mism;
        logic [FRAME_CYC-1:0] smp_tx, smp_busy, smp_done, exp_done;
        exp_done = '0;
        exp_done[FRAME_CYC-1] = 1'b1;
        forever begin
            tick();
            if (rst) begin
                prev_tx = 1'b1;
            end else if (prev_tx && !bus.tx) begin
                mon_active = 1'b1;
                start_cyc  = ncyc;
                check("rd_to_start", start_cyc - last_rd, 2);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                end else begin
                    check("frame_expected", 0, 1);
                    e = '{data: 8'h00, frame: 11'h0, b2b: 1'b0, abort: 1'b0};
                end
                if (e.b2b) check("b2b_gap", start_cyc - last_end - 1, 3);
                smp_tx = '0; smp_busy = '0; smp_done = '0;
                smp_tx[0] = bus.tx; smp_busy[0] = bus.busy; smp_done[0] = bus.tx_done;
                aborted = 1'b0;
                for (int i = 1; i < FRAME_CYC; i++) begin
                    tick();
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp_tx[i] = bus.tx; smp_busy[i] = bus.busy; smp_done[i] = bus.tx_done;
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                check("abort_seen", aborted, e.abort);
                if (aborted) begin
                    while (rst) tick();
                end else begin
                    for (int k = 0; k < 8; k++) got[k] = smp_tx[(k + 1) * CPB + CPB / 2];
                    check("byte", got, e.data);
                    mism = 0;
                    for (int i = 0; i < FRAME_CYC; i++)
                        if (smp_tx[i] !== e.frame[i / CPB]) mism++;
                    check("tx_waveform", mism, 0);
                    check("tx_done_pos", smp_done, exp_done);
                    check("busy_in_frame", smp_busy, {FRAME_CYC{1'b1}});
                    last_end = ncyc;
                    tick();
                    check("busy_fall", bus.busy, 0);
                end
                mon_active = 1'b0;
                prev_tx = bus.tx;
                continue;
            end
            prev_tx = bus.tx;
        end
    end

    initial begin : stimulus
        int n_tx, n_rd, n_busy, n_done;
        rst = 1'b1;
        push_byte(8'hA5, F_A5, 1'b0, 1'b0);
        n_tx = 0; n_rd = 0; n_busy = 0; n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.tx !== 1'b1)      n_tx++;
            if (bus.fifo_rd !== 1'b0) n_rd++;
            if (bus.busy !== 1'b0)    n_busy++;
            if (bus.tx_done !== 1'b0) n_done++;
        end
        check("rst_fifo_empty_low", bus.fifo_empty, 0);
        check("rst_tx_high", n_tx, 0);
        check("rst_no_rd", n_rd, 0);
        check("rst_busy_low", n_busy, 0);
        check("rst_tx_done_low", n_done, 0);
        #1 rst = 1'b0;

        wait_drain("drain_a5", 200);
        check("rd_count_a5", rd_count, 1);

        push_byte(8'h00, F_00, 1'b0, 1'b0);
        push_byte(8'hFF, F_FF, 1'b1, 1'b0);
        wait_drain("drain_b2b", 300);
        check("rd_count_b2b", rd_count, 3);

        n_tx = 0; n_rd = 0; n_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx !== 1'b1)      n_tx++;
            if (bus.fifo_rd !== 1'b0) n_rd++;
            if (bus.busy !== 1'b0)    n_busy++;
        end
        check("empty_no_rd", n_rd, 0);
        check("empty_tx_high", n_tx, 0);
        check("empty_not_busy", n_busy, 0);

        // Mid-frame reset during data bit 3 of 0x3C.
        push_byte(8'h3C, F_3C, 1'b0, 1'b1);
        n_rd = 0;
        while (!bus.fifo_rd && n_rd < 50) begin
            @(negedge clk);
            n_rd++;
        end
        check("abort_rd_seen", bus.fifo_rd, 1);
        repeat (19) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_tx_high", bus.tx, 1);
        check("abort_busy_low", bus.busy, 0);
        check("abort_tx_done_low", bus.tx_done, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        n_tx = 0; n_rd = 0; n_busy = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.tx !== 1'b1)      n_tx++;
            if (bus.fifo_rd !== 1'b0) n_rd++;
            if (bus.busy !== 1'b0)    n_busy++;
        end
        check("post_abort_no_rd", n_rd, 0);
        check("post_abort_tx_high", n_tx, 0);
        check("post_abort_not_busy", n_busy, 0);
        check("rd_count_abort", rd_count, 4);
        wait_drain("drain_abort", 10);

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07, F_07, 1'b0, 1'b0);
        wait_drain("drain_parity", 200);
        check("rd_count_parity", rd_count, 5);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end
endmodule
